// File: rtl/mem_dump_reader.sv
// mem_dump_reader
//   Button-stepped readback of the data memory once the CPU has halted.
//   Each debounced press of next_btn advances to the next memory entry. The
//   word read there is latched for the 7-segment display, and a one-hot LED
//   bar marks which entry is on show. Stepping past the last entry lights
//   every LED and raises done.
//
// Ports
//   clk            system clock, all state on posedge
//   clr            asynchronous active-low reset
//   start          level: 1 = CPU halted and dump enabled, 0 = abort to idle
//   next_btn       raw push button, asynchronous to clk, may bounce
//   Mem_read_data  combinational read data from the memory at Mem_read_addr
//   Mem_read_addr  registered read address driven to the memory
//   show_data      latched word of the entry on display
//   display_led    one-hot entry indicator, MSB = entry 0, all ones when done
//   busy           high while an entry is being loaded or shown
//   done           high once the last entry has been stepped past
module mem_dump_reader #(
  parameter int DEPTH     = 10,
  parameter int AW        = 4,
  parameter int DW        = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             next_btn,
  input  logic [DW-1:0]    Mem_read_data,
  output logic [AW-1:0]    Mem_read_addr,
  output logic [DW-1:0]    show_data,
  output logic [DEPTH-1:0] display_led,
  output logic             busy,
  output logic             done
);

  // One extra counter bit keeps the width non-zero even when DB_CYCLES is 1.
  localparam int CW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW, DONE} state_t;

  logic          sync1, sync2;
  logic          stable, stable_d;
  logic [CW-1:0] db_cnt;
  logic          step;

  state_t           state, state_nx;
  logic [AW-1:0]    addr_nx;
  logic [DW-1:0]    show_nx;
  logic [DEPTH-1:0] led_nx;
  logic [DEPTH-1:0] led_onehot;

  // Button conditioning. The raw button goes through a two-flop synchronizer.
  // The synced level is then accepted as the new stable level only after it
  // has disagreed with the stable level for DB_CYCLES consecutive cycles. Any
  // bounce back to agreement restarts the count. stable_d keeps last cycle's
  // stable level so that a rising edge can be detected.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= next_btn;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  // One pulse per press. Releasing the button (a falling stable level) never
  // produces a step.
  assign step = stable & ~stable_d;

  // LED pattern for the current address. Entry 0 lights the MSB, so the bar
  // walks from left to right as the dump advances.
  always_comb begin
    led_onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Mem_read_addr == AW'(i)) led_onehot[DEPTH-1-i] = 1'b1;
    end
  end

  // State register together with the display and address registers. All of
  // them move only under the control of the next-state logic below.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= IDLE;
      Mem_read_addr <= '0;
      show_data     <= '0;
      display_led   <= '0;
    end else begin
      state         <= state_nx;
      Mem_read_addr <= addr_nx;
      show_data     <= show_nx;
      display_led   <= led_nx;
    end
  end

  // Next-state logic. Dropping start always wins, even over a simultaneous
  // step. A step that arrives while nothing is waiting for it (IDLE, LOAD or
  // DONE) is simply dropped. The address is bumped when leaving SHOW, so it
  // has been stable for a full cycle before LOAD samples the combinational
  // memory data.
  always_comb begin
    state_nx = state;
    addr_nx  = Mem_read_addr;
    show_nx  = show_data;
    led_nx   = display_led;
    case (state)
      IDLE: begin
        addr_nx = '0;
        led_nx  = '0;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        if (!start) begin
          state_nx = IDLE;
          addr_nx  = '0;
          led_nx   = '0;
        end else begin
          show_nx  = Mem_read_data;
          led_nx   = led_onehot;
          state_nx = SHOW;
        end
      end
      SHOW: begin
        if (!start) begin
          state_nx = IDLE;
          addr_nx  = '0;
          led_nx   = '0;
        end else if (step) begin
          if (Mem_read_addr < AW'(DEPTH - 1)) begin
            addr_nx  = Mem_read_addr + AW'(1);
            state_nx = LOAD;
          end else begin
            led_nx   = '1;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        if (!start) begin
          state_nx = IDLE;
          addr_nx  = '0;
          led_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        addr_nx  = '0;
        led_nx   = '0;
      end
    endcase
  end

  assign busy = (state == LOAD) || (state == SHOW);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader
//   Self-checking bench for mem_dump_reader. A small array stands in for the
//   data memory. A behavioural model tracks which entry should be on display
//   and whether the dump is idle, showing or finished. The bench drives
//   directed scenarios first, then a randomized mix of presses, glitches and
//   aborts over random memory contents.
module tb_mem_dump_reader;

  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DB    = 4;

  logic             clk;
  logic             clr;
  logic             start;
  logic             next_btn;
  logic [DW-1:0]    Mem_read_data;
  logic [AW-1:0]    Mem_read_addr;
  logic [DW-1:0]    show_data;
  logic [DEPTH-1:0] display_led;
  logic             busy;
  logic             done;

  logic [DW-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase 0 = idle, 1 = showing entry m_idx, 2 = finished.
  int            m_phase;
  int            m_idx;
  logic [DW-1:0] m_show;

  mem_dump_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .DB_CYCLES(DB)) dut (
    .clk           (clk),
    .clr           (clr),
    .start         (start),
    .next_btn      (next_btn),
    .Mem_read_data (Mem_read_data),
    .Mem_read_addr (Mem_read_addr),
    .show_data     (show_data),
    .display_led   (display_led),
    .busy          (busy),
    .done          (done)
  );

  // The memory's asynchronous read port.
  assign Mem_read_data = (int'(Mem_read_addr) < DEPTH) ? mem[Mem_read_addr] : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs are driven and outputs sampled on the falling edge, away from the
  // active edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Compare every output against what the model says should be on display.
  task automatic checkState(input string tag);
    logic [DEPTH-1:0] exp_led;
    if (m_phase == 0)      exp_led = '0;
    else if (m_phase == 2) exp_led = '1;
    else                   exp_led = DEPTH'(1) << (DEPTH - 1 - m_idx);
    checkOutput({tag, ".addr"}, 32'(Mem_read_addr), (m_phase == 0) ? 32'd0 : 32'(m_idx));
    checkOutput({tag, ".show"}, 32'(show_data), 32'(m_show));
    checkOutput({tag, ".led"},  32'(display_led), 32'(exp_led));
    checkOutput({tag, ".busy"}, 32'(busy), (m_phase == 1) ? 32'd1 : 32'd0);
    checkOutput({tag, ".done"}, 32'(done), (m_phase == 2) ? 32'd1 : 32'd0);
  endtask

  // A raw button pulse: high for hold cycles, then low for gap cycles.
  task automatic applyStimulus(input int hold, input int gap);
    next_btn = 1'b1;
    tick(hold);
    next_btn = 1'b0;
    tick(gap);
  endtask

  // Model of one accepted press.
  task automatic modelStep();
    if (m_phase == 1) begin
      if (m_idx < DEPTH - 1) begin
        m_idx++;
        m_show = mem[m_idx];
      end else begin
        m_phase = 2;
      end
    end
  endtask

  // A clean press long enough to debounce, followed by enough quiet time for
  // the release to settle.
  task automatic press();
    applyStimulus($urandom_range(DB + 4, DB + 20), $urandom_range(DB + 8, DB + 20));
    modelStep();
  endtask

  // A pulse too short to survive the debouncer.
  task automatic glitch(input int len);
    applyStimulus(len, DB + 8);
  endtask

  task automatic setStart(input logic v);
    start = v;
    tick(3);
    if (!v) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
      m_idx   = 0;
      m_show  = mem[0];
    end
  endtask

  initial begin
    int old;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hA000 + 16'(i);
    clr      = 1'b0;
    start    = 1'b0;
    next_btn = 1'b0;
    m_phase  = 0;
    m_idx    = 0;
    m_show   = '0;

    // Reset state.
    tick(3);
    checkState("reset");
    clr = 1'b1;
    tick(2);
    checkState("idle");

    // First entry appears two cycles after start rises.
    start = 1'b1;
    tick(1);
    checkOutput("load.busy", 32'(busy), 32'd1);
    tick(1);
    m_phase = 1; m_idx = 0; m_show = mem[0];
    checkOutput("first.show", 32'(show_data), 32'hA000);
    checkOutput("first.led",  32'(display_led), 32'h200);
    checkState("first");

    // Pulses one cycle short of the debounce length never step.
    for (int k = 1; k < DB; k++) begin
      glitch(DB - 1);
      checkState("glitch");
    end

    // A held button steps exactly once, DB+3 cycles after the rise.
    old = m_idx;
    next_btn = 1'b1;
    tick(DB + 2);
    checkOutput("hold.before", 32'(Mem_read_addr), 32'(old));
    tick(1);
    checkOutput("hold.at", 32'(Mem_read_addr), 32'(old + 1));
    tick(100 - (DB + 3));
    modelStep();
    checkState("hold.long");
    next_btn = 1'b0;
    tick(DB + 10);
    checkState("hold.release");

    // Advance to entry 3, then drop start in the very cycle the step fires.
    while (m_idx < 3) press();
    checkState("at3");
    next_btn = 1'b1;
    tick(DB + 2);
    start = 1'b0;
    tick(1);
    m_phase = 0;
    checkOutput("abort.addr", 32'(Mem_read_addr), 32'd0);
    checkOutput("abort.busy", 32'(busy), 32'd0);
    next_btn = 1'b0;
    tick(DB + 10);
    checkState("abort.idle");
    start = 1'b1;
    tick(2);
    m_phase = 1; m_idx = 0; m_show = mem[0];
    checkOutput("restart.show", 32'(show_data), 32'hA000);
    checkState("restart");

    // Full walk: nine presses through the entries, a tenth to finish.
    for (int k = 1; k < DEPTH; k++) begin
      press();
      checkState("walk");
    end
    checkOutput("walk.last", 32'(display_led), 32'h001);
    press();
    checkOutput("fin.done", 32'(done), 32'd1);
    checkOutput("fin.show", 32'(show_data), 32'hA009);
    checkState("fin");

    // Asynchronous reset in the middle of a dump.
    setStart(1'b0);
    setStart(1'b1);
    while (m_idx < 5) press();
    checkState("at5");
    @(negedge clk);
    #2;
    clr = 1'b0;
    #1;
    m_phase = 0; m_idx = 0; m_show = '0;
    checkState("async");
    start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    tick(2);
    checkState("async.idle");
    setStart(1'b1);
    checkState("async.restart");
    for (int k = 0; k < DEPTH; k++) press();
    checkState("done2");
    press();
    checkState("done.press");

    // Random memory contents with a random mix of operations.
    setStart(1'b0);
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    setStart(1'b1);
    checkState("rnd.start");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: press();
        6, 7:             glitch($urandom_range(1, DB - 1));
        8: begin
          setStart(1'b0);
          checkState("rnd.abort");
          setStart(1'b1);
        end
        default:          tick($urandom_range(1, 10));
      endcase
      checkState("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
